// File: rtl/matrix_block_sequencer.sv
// matrix_block_sequencer: runs the stream reader and the compute/output loop
// back to back once per matrix block, for a latched number of blocks.
// ap_ctrl_hs-style handshake upward, start/done pulses downward.
// Optional stall watchdog: define SEQ_STALL_WATCHDOG_EN to build it.
module matrix_block_sequencer #(
  parameter int unsigned NUM_BLOCKS_W = 16,
  parameter int unsigned WDOG_W       = 16
) (
  input  logic                    ap_clk,
  input  logic                    ap_rst,
  input  logic                    ap_start,
  output logic                    ap_done,
  output logic                    ap_idle,
  output logic                    ap_ready,
  input  logic [NUM_BLOCKS_W-1:0] num_blocks,
  input  logic [WDOG_W-1:0]       wdog_limit,
  output logic                    rd_start,
  input  logic                    rd_done,
  input  logic                    rd_blk,
  output logic                    mm_start,
  input  logic                    mm_done,
  input  logic                    mm_blk,
  output logic [NUM_BLOCKS_W-1:0] blocks_done,
  output logic                    stall,
  output logic                    stall_phase
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD_START,
    S_RD_WAIT,
    S_MM_START,
    S_MM_WAIT,
    S_FIN
  } state_t;

  localparam logic [NUM_BLOCKS_W-1:0] BLK_ONE = {{(NUM_BLOCKS_W-1){1'b0}}, 1'b1};

  state_t                  state;
  state_t                  state_nxt;
  logic [NUM_BLOCKS_W-1:0] nb_q;
  logic [NUM_BLOCKS_W-1:0] bd_inc;
  logic                    accept;

  assign bd_inc = blocks_done + BLK_ONE;
  assign accept = (state == S_IDLE) && ap_start;

  // Next-state decode; done inputs are only honoured in their own WAIT state
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:     if (ap_start) state_nxt = (num_blocks == '0) ? S_FIN : S_RD_START;
      S_RD_START: state_nxt = S_RD_WAIT;
      S_RD_WAIT:  if (rd_done) state_nxt = S_MM_START;
      S_MM_START: state_nxt = S_MM_WAIT;
      S_MM_WAIT:  if (mm_done) state_nxt = (bd_inc == nb_q) ? S_FIN : S_RD_START;
      S_FIN:      state_nxt = S_IDLE;
      default:    state_nxt = S_IDLE;
    endcase
  end

  // State, latched block count and completed-block counter
  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      state       <= S_IDLE;
      nb_q        <= '0;
      blocks_done <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        nb_q        <= num_blocks;
        blocks_done <= '0;
      end else if ((state == S_MM_WAIT) && mm_done) begin
        blocks_done <= bd_inc;
      end
    end
  end

  assign ap_idle  = (state == S_IDLE);
  assign ap_done  = (state == S_FIN);
  assign ap_ready = (state == S_FIN);
  assign rd_start = (state == S_RD_START);
  assign mm_start = (state == S_MM_START);

`ifdef SEQ_STALL_WATCHDOG_EN
  localparam logic [WDOG_W-1:0] WD_ONE = {{(WDOG_W-1){1'b0}}, 1'b1};

  logic [WDOG_W-1:0] wl_q;
  logic [WDOG_W-1:0] wd_cnt;
  logic [WDOG_W-1:0] wd_inc;
  logic [WDOG_W-1:0] wd_cnt_nxt;
  logic              wd_active;
  logic              wd_hit;

  // Saturating count of consecutive blocked cycles in the current WAIT state;
  // the incremented value is compared so the flag lands on the reaching edge
  always_comb begin
    wd_active  = ((state == S_RD_WAIT) && rd_blk) || ((state == S_MM_WAIT) && mm_blk);
    wd_inc     = (wd_cnt == '1) ? wd_cnt : wd_cnt + WD_ONE;
    wd_hit     = wd_active && (wl_q != '0) && (wd_inc == wl_q);
    wd_cnt_nxt = '0;
    if (wd_active && (state_nxt == state)) wd_cnt_nxt = wd_inc;
  end

  // Watchdog registers; stall is sticky and keeps the first tripping phase
  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      wl_q        <= '0;
      wd_cnt      <= '0;
      stall       <= 1'b0;
      stall_phase <= 1'b0;
    end else if (accept) begin
      wl_q        <= wdog_limit;
      wd_cnt      <= '0;
      stall       <= 1'b0;
      stall_phase <= 1'b0;
    end else begin
      wd_cnt <= wd_cnt_nxt;
      if (wd_hit && !stall) begin
        stall       <= 1'b1;
        stall_phase <= (state == S_MM_WAIT);
      end
    end
  end
`else
  logic unused_wdog;

  assign unused_wdog = ^{wdog_limit, rd_blk, mm_blk};
  assign stall       = 1'b0;
  assign stall_phase = 1'b0;
`endif

endmodule
